// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode, flag-index and flag-width definitions for the ALU path
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int FLG_Z  = 3;
  localparam int FLG_N  = 2;
  localparam int FLG_C  = 1;
  localparam int FLG_V  = 0;
  localparam int FLAG_W = 4;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_issue_if.sv
`default_nettype none
// ============================================================================
// alu_cmd_issue_if : command, ALU-side and response signals of the issue stage
// Rev 1.0
// ============================================================================
interface alu_cmd_issue_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_a;
  logic [WIDTH-1:0]  cmd_b;
  logic [1:0]        cmd_op;
  logic [TAG_W-1:0]  cmd_tag;

  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [1:0]        alu_op;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_z;
  logic              alu_n;
  logic              alu_c;
  logic              alu_v;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_result;
  logic [FLAG_W-1:0] rsp_flags;
  logic [TAG_W-1:0]  rsp_tag;
  logic              busy;

  // Environment side: command source, ALU and response sink
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_z, alu_n, alu_c, alu_v,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag,
    output rsp_ready,
    input  busy
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_z, alu_n, alu_c, alu_v,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag,
    input  rsp_ready,
    output busy
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO, head read straight from storage, no fall-through
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (rd_en) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// alu_cmd_issue : credit-based command issue and result capture for the ALU
// Rev 1.0
// ============================================================================
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 4,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic           clk,
  input  logic           rst,
  alu_cmd_issue_if.slave bus
);

  localparam int CMD_W = 2 * WIDTH + 2 + TAG_W;
  localparam int RSP_W = WIDTH + FLAG_W + TAG_W;
  localparam int CRD_W = $clog2(RSP_DEPTH + 1);
  localparam int CCN_W = $clog2(CMD_DEPTH + 1);
  localparam int RCN_W = $clog2(RSP_DEPTH + 1);

  logic              cmd_push, cmd_full, cmd_empty, issue;
  logic [CMD_W-1:0]  cmd_head;
  logic [CCN_W-1:0]  cmd_cnt, cmd_cnt_d;
  logic              rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [RSP_W-1:0]  rsp_wdata, rsp_head;
  logic [RCN_W-1:0]  rsp_cnt, rsp_cnt_d;
  logic [FLAG_W-1:0] alu_flags;

  logic [CRD_W-1:0]  credit_q, credit_d;
  logic [WIDTH-1:0]  alu_a_q, alu_b_q;
  logic [1:0]        alu_op_q;
  logic [ALU_LAT:0]  infl_vld_q, infl_vld_d;
  logic [TAG_W-1:0]  infl_tag_q [ALU_LAT+1];
  logic              busy_q, busy_d;

  assign bus.cmd_ready = !cmd_full && !rst;
  assign cmd_push      = bus.cmd_valid && bus.cmd_ready;
  // A free credit guarantees a response-FIFO slot by the time the result lands
  assign issue         = !cmd_empty && (credit_q != '0);

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_push),
    .data_i  ({bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag}),
    .pop_i   (issue),
    .data_o  (cmd_head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .count_o (cmd_cnt)
  );

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLG_Z]  = bus.alu_z;
    alu_flags[FLG_N]  = bus.alu_n;
    alu_flags[FLG_C]  = bus.alu_c;
    alu_flags[FLG_V]  = bus.alu_v;
  end

  assign rsp_push  = infl_vld_q[ALU_LAT] && !rsp_full;
  assign rsp_wdata = {bus.alu_result, alu_flags, infl_tag_q[ALU_LAT]};
  assign rsp_pop   = bus.rsp_valid && bus.rsp_ready;

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_push),
    .data_i  (rsp_wdata),
    .pop_i   (rsp_pop),
    .data_o  (rsp_head),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .count_o (rsp_cnt)
  );

  assign bus.rsp_valid  = !rsp_empty;
  assign bus.rsp_result = rsp_head[RSP_W-1 -: WIDTH];
  assign bus.rsp_flags  = rsp_head[TAG_W +: FLAG_W];
  assign bus.rsp_tag    = rsp_head[TAG_W-1:0];
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.busy       = busy_q;

  always_comb begin
    credit_d   = credit_q + CRD_W'(rsp_pop) - CRD_W'(issue);
    infl_vld_d = {infl_vld_q[ALU_LAT-1:0], issue};
    cmd_cnt_d  = cmd_cnt + CCN_W'(cmd_push) - CCN_W'(issue);
    rsp_cnt_d  = rsp_cnt + RCN_W'(rsp_push) - RCN_W'(rsp_pop);
    busy_d     = (cmd_cnt_d != '0) || (infl_vld_d != '0) || (rsp_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q   <= CRD_W'(RSP_DEPTH);
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 2'b00;
      infl_vld_q <= '0;
      busy_q     <= 1'b0;
      for (int i = 0; i <= ALU_LAT; i++) begin
        infl_tag_q[i] <= '0;
      end
    end else begin
      credit_q   <= credit_d;
      infl_vld_q <= infl_vld_d;
      busy_q     <= busy_d;
      if (issue) begin
        alu_a_q  <= cmd_head[CMD_W-1 -: WIDTH];
        alu_b_q  <= cmd_head[TAG_W+2 +: WIDTH];
        alu_op_q <= cmd_head[TAG_W +: 2];
      end
      infl_tag_q[0] <= cmd_head[TAG_W-1:0];
      for (int i = 1; i <= ALU_LAT; i++) begin
        infl_tag_q[i] <= infl_tag_q[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issue.sv
`default_nettype none
// ============================================================================
// tb_alu_cmd_issue : randomized and directed bench with a queue-based reference
// Rev 1.0
// ============================================================================
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int WIDTH     = 32;
  localparam int TAG_W     = 4;
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int ALU_LAT   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_issue_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_cmd_issue #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .CMD_DEPTH(CMD_DEPTH),
    .RSP_DEPTH(RSP_DEPTH), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_rsp    = 0;
  int          run_len  = 0;
  int          max_run  = 0;
  logic        prev_stall = 1'b0;
  logic [39:0] prev_rsp   = '0;

  // Architectural result and {Z,N,C,V}; C on SUB means "no borrow"
  function automatic logic [35:0] ref_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_AND:  r = a & b;
      default: r = a | b;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Registered ALU with one cycle of latency
  always @(posedge clk) begin
    if (rst) begin
      {bus.alu_result, bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v} <= '0;
    end else begin
      {bus.alu_result, bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v} <=
        ref_calc(bus.alu_a, bus.alu_b, bus.alu_op);
    end
  end

  // Scoreboard: expectations enter at command handshake, leave at response handshake
  always @(negedge clk) begin : mon
    logic [35:0] r;
    exp_t        e;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      run_len    = 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        r = ref_calc(bus.cmd_a, bus.cmd_b, bus.cmd_op);
        exp_q.push_back('{res: r[35:4], flg: r[3:0], tag: bus.cmd_tag});
      end
      if (prev_stall) begin
        check("rsp_stable", {bus.rsp_result, bus.rsp_flags, bus.rsp_tag}, prev_rsp);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_result", bus.rsp_result, e.res);
          check("rsp_flags", bus.rsp_flags, e.flg);
          check("rsp_tag", bus.rsp_tag, e.tag);
        end
      end
      run_len    = bus.rsp_valid ? run_len + 1 : 0;
      max_run    = (run_len > max_run) ? run_len : max_run;
      prev_stall = bus.rsp_valid && !bus.rsp_ready;
      prev_rsp   = {bus.rsp_result, bus.rsp_flags, bus.rsp_tag};
    end
  end

  // Called at posedge+1; returns just after the accepting edge with cmd_valid still high
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [3:0] tag, output int stalls);
    logic hs;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_tag   = tag;
    stalls        = 0;
    while (1) begin
      @(negedge clk);
      hs = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      stalls++;
      if (stalls > 200) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic lat_check(input string name);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check(name, bus.rsp_valid, (k == 3));
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("drain_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  logic done;
  int   st, tot, base;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b1;
    done          = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;

    send(32'h5, 32'h3, OP_ADD, 4'd1, st);
    bus.cmd_valid = 1'b0;
    lat_check("single_latency");
    check("single_result", bus.rsp_result, 32'h8);
    check("single_flags", bus.rsp_flags, 4'b0000);
    check("single_tag", bus.rsp_tag, 4'd1);
    wait_drain(50);

    send(32'hFFFF_FFFF, 32'h1, OP_ADD, 4'd2, st);
    bus.cmd_valid = 1'b0;
    lat_check("carry_latency");
    check("carry_result", bus.rsp_result, 32'h0);
    check("carry_flags", bus.rsp_flags, 4'b1010);
    wait_drain(50);
    send(32'h6, 32'h2, OP_AND, 4'd3, st);
    send(32'h6, 32'h2, OP_OR, 4'd4, st);
    send(32'h2, 32'h6, OP_SUB, 4'd5, st);
    bus.cmd_valid = 1'b0;
    wait_drain(50);

    // Streaming at full rate
    max_run = 0;
    base    = n_rsp;
    tot     = 0;
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 2'($urandom_range(0, 3)), 4'(i), st);
      tot += st;
    end
    bus.cmd_valid = 1'b0;
    wait_drain(50);
    check("stream_stalls", tot, 0);
    check("stream_run", max_run, 8);
    check("stream_count", n_rsp - base, 8);

    // Backpressure: credits cap issue at RSP_DEPTH, then the command FIFO fills
    bus.rsp_ready = 1'b0;
    base = n_rsp;
    tot  = 0;
    for (int i = 0; i < 8; i++) begin
      send(32'd100 + 32'(i), 32'(i), OP_ADD, 4'(i), st);
      tot += st;
    end
    bus.cmd_valid = 1'b0;
    check("bp_accept_stalls", tot, 0);
    @(negedge clk);
    check("bp_cmd_ready_drop", bus.cmd_ready, 0);
    repeat (5) @(negedge clk);
    check("bp_cmd_ready_hold", bus.cmd_ready, 0);
    check("bp_last_issued_a", bus.alu_a, 32'd103);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    check("bp_head_tag", bus.rsp_tag, 4'd0);
    check("bp_busy", bus.busy, 1);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    send(32'd108, 32'd8, OP_ADD, 4'd8, st);
    send(32'd109, 32'd9, OP_ADD, 4'd9, st);
    bus.cmd_valid = 1'b0;
    wait_drain(100);
    check("bp_rsp_count", n_rsp - base, 10);

    // Reset with work queued and in flight
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(32'(i), 32'd7, OP_SUB, 4'(10 + i), st);
    end
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midrst_no_stale", bus.rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    send(32'h1, 32'h1, OP_ADD, 4'd6, st);
    bus.cmd_valid = 1'b0;
    lat_check("midrst_latency");
    check("midrst_result", bus.rsp_result, 32'h2);
    check("midrst_tag", bus.rsp_tag, 4'd6);
    wait_drain(50);

    // Random commands under random response backpressure
    base = n_rsp;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send($urandom, $urandom, 2'($urandom_range(0, 3)), 4'($urandom), st);
          if ($urandom_range(0, 3) == 0) begin
            bus.cmd_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        bus.cmd_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_drain(200);
    check("rand_rsp_count", n_rsp - base, 40);
    check("final_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
